histeq_master_sequencer: RTL and testbench
==========================================

# histeq_master_sequencer

Top-level sequencer that drives the histogram equalizer core's phase-control inputs and consumes its completion outputs. It runs the three phases in order: histogram, CDF, divider/mapping. It also generates `input_mem_read_finished` by watching the core's input-memory read address, and detects divider completion by counting output-memory write strobes. Per-phase watchdogs and protocol checks report failures to the system host.

## Interface
Parameters:
- `INPUT_WORDS`, default 4096: number of 128-bit input-memory words read during the histogram phase.
- `OUTPUT_WORDS`, default 4096: number of output-memory writes that complete the divider phase.
- `TIMEOUT_W`, default 20: width of the phase watchdog counter.
- `TIMEOUT_CYCLES`, default 20'hFFFFF: cycles a phase may stay active before the watchdog fires.

Ports:
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `go`  in  1  host start; sampled only in IDLE.
- `clear`  in  1  synchronous abort; returns to IDLE from any state.
- `histogram_computation_done`  in  1  from core.
- `cdf_done`  in  1  from core.
- `histogram_input_mem_raddr0`  in  16  from core; monitored.
- `divider_output_mem_WE`  in  1  from core; monitored.
- `start_histogram`  out  1  level; high for the whole HIST phase.
- `start_cdf`  out  1  level; high for the whole CDF phase.
- `start_divider`  out  1  level; high for the whole DIV phase.
- `input_mem_read_finished`  out  1  level; set in HIST, cleared on leaving HIST.
- `busy`  out  1  high in HIST, CDF and DIV.
- `done`  out  1  one-cycle pulse on successful completion.
- `error`  out  1  high while in ERR.
- `err_code`  out  2  cause: 00 none, 01 watchdog timeout, 10 protocol error; holds its value until `clear` or reset.

## Operation
- States: IDLE, HIST, CDF, DIV, FIN, ERR.
- IDLE: when `go`=1 and `clear`=0, move to HIST. Entering HIST clears the watchdog, the write counter and `input_mem_read_finished`.
- HIST:
  - Sampling `histogram_input_mem_raddr0 == INPUT_WORDS-1` sets `input_mem_read_finished`. The flag stays set until HIST is left.
  - `histogram_computation_done`=1 with the flag already set moves to CDF.
  - `histogram_computation_done`=1 with the flag clear is a protocol error: go to ERR with `err_code`=10.
- CDF: `cdf_done`=1 moves to DIV.
- DIV:
  - Each cycle with `divider_output_mem_WE`=1 increments a 16-bit write counter.
  - The WE that brings the count to `OUTPUT_WORDS` moves to FIN.
  - WE seen outside DIV is ignored and not counted.
- FIN: `done`=1 for exactly one cycle, then IDLE.
- Watchdog:
  - Resets to 0 on every phase entry and increments each cycle in HIST, CDF or DIV.
  - Reaching `TIMEOUT_CYCLES` moves to ERR with `err_code`=01.
- ERR: all `start_*` low and `error`=1. Leaves only on `clear` or reset.
- `clear`=1 from any state: go to IDLE next edge, drop all `start_*`, and zero `err_code`, the counters and `input_mem_read_finished`.
- Priority within one cycle: `clear`, then phase completion, then protocol error, then watchdog.
- `go` while busy or in ERR is ignored.

## Timing
- All outputs are registered, decoded from the state register and flags.
- Reset value of every output is 0; state is IDLE.
- `go` sampled at edge N: `start_histogram` and `busy` are high after edge N.
- `histogram_computation_done` sampled at edge N: after edge N, `start_histogram`=0 and `start_cdf`=1. There is no gap cycle and no overlap. The same applies to CDF→DIV.
- Final WE sampled at edge N: after edge N, `start_divider`=0, `busy`=0 and `done`=1. After edge N+1, `done`=0.
- `input_mem_read_finished` is high the cycle after the matching address is sampled.
- Watchdog: the phase is entered at edge N. If it has not completed, ERR is entered at edge N+`TIMEOUT_CYCLES`.
- Asynchronous reset mid-phase: all outputs drop to 0 immediately and the state is IDLE.

## Structure
- Shared package `histeq_pkg`:
  - state enum (IDLE, HIST, CDF, DIV, FIN, ERR)
  - `err_code` constants ERR_NONE, ERR_TIMEOUT, ERR_PROTOCOL
  - default image word counts.
- One sub-module, `histeq_phase_timer`:
  - inputs: `clock`, `reset`, `restart`, `enable`
  - output: `expired`
  - parameters: `TIMEOUT_W`, `TIMEOUT_CYCLES`
  - instantiated once and restarted on every phase entry.

## Test plan
- Nominal run (`INPUT_WORDS`=4, `OUTPUT_WORDS`=4): pulse `go`; sweep raddr0 0..3; then `histogram_computation_done`, then `cdf_done`, then 4 WE pulses. Expect the `start_*` levels in sequence with no overlap, `input_mem_read_finished` one cycle after raddr0=3, and `done` for exactly 1 cycle after the 4th WE.
- Protocol error: `histogram_computation_done` arrives before raddr0 reaches 3. Expect ERR with `error`=1, `err_code`=10 and all starts low. Then `clear` → IDLE with `err_code`=00.
- Watchdog (`TIMEOUT_CYCLES`=8): enter CDF and never assert `cdf_done`. Expect ERR 8 cycles after CDF entry with `err_code`=01. Also assert `cdf_done` on the 8th cycle: completion wins and DIV is entered.
- Spurious inputs: WE pulses during HIST and CDF, plus `go` pulses while busy. Expect no effect; DIV still needs 4 counted WEs.
- `clear` mid-DIV after 2 WEs: IDLE next cycle. A new `go` restarts HIST with the write counter at 0.
- Asynchronous reset asserted mid-HIST between clock edges: all outputs 0 immediately. After release, IDLE and waiting for `go`.

Source files
------------

// File: rtl/histeq_pkg.sv
// Shared types and constants for the histogram-equalizer master sequencer.
package histeq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HIST = 3'd1,
    CDF  = 3'd2,
    DIV  = 3'd3,
    FIN  = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_PROTOCOL = 2'b10;

  localparam int unsigned DEF_INPUT_WORDS    = 4096;
  localparam int unsigned DEF_OUTPUT_WORDS   = 4096;
  localparam int unsigned DEF_TIMEOUT_W      = 20;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 20'hFFFFF;
  localparam int unsigned ADDR_W             = 16;
  localparam int unsigned WCNT_W             = 16;

  // True for the three states in which the core is actively running a phase.
  function automatic logic is_phase(input state_t s);
    return (s == HIST) || (s == CDF) || (s == DIV);
  endfunction

endpackage

// File: rtl/histeq_phase_timer.sv
// Per-phase watchdog: counts active cycles since the last restart and flags
// expiry one cycle ahead so the sequencer leaves exactly TIMEOUT_CYCLES after entry.
module histeq_phase_timer #(
  parameter int unsigned TIMEOUT_W      = 20,
  parameter int unsigned TIMEOUT_CYCLES = 20'hFFFFF
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMEOUT_W-1:0] LAST_COUNT = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic FIRE_AT_ENTRY = (TIMEOUT_CYCLES == 1);

  logic [TIMEOUT_W-1:0] count;
  logic [TIMEOUT_W-1:0] count_inc;

  assign count_inc = count + TIMEOUT_W'(1);

  // Counter and expiry flag; restart wins over counting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (restart) begin
      count   <= '0;
      expired <= FIRE_AT_ENTRY;
    end else if (enable) begin
      count   <= count_inc;
      expired <= (count_inc == LAST_COUNT);
    end
  end

endmodule

// File: rtl/histeq_master_sequencer.sv
// Master sequencer for the histogram equalizer core: runs HIST -> CDF -> DIV,
// tracks input-memory read completion and output writes, and reports errors.
module histeq_master_sequencer
  import histeq_pkg::*;
#(
  parameter int unsigned INPUT_WORDS    = DEF_INPUT_WORDS,
  parameter int unsigned OUTPUT_WORDS   = DEF_OUTPUT_WORDS,
  parameter int unsigned TIMEOUT_W      = DEF_TIMEOUT_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              go,
  input  logic              clear,
  input  logic              histogram_computation_done,
  input  logic              cdf_done,
  input  logic [ADDR_W-1:0] histogram_input_mem_raddr0,
  input  logic              divider_output_mem_WE,
  output logic              start_histogram,
  output logic              start_cdf,
  output logic              start_divider,
  output logic              input_mem_read_finished,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam logic [ADDR_W-1:0] LAST_RADDR  = ADDR_W'(INPUT_WORDS - 1);
  localparam logic [WCNT_W-1:0] FINAL_WRITE = WCNT_W'(OUTPUT_WORDS);

  state_t              state, state_d;
  logic                read_fin, read_fin_d;
  logic [WCNT_W-1:0]   wr_cnt, wr_cnt_d, wr_cnt_inc;
  logic [1:0]          err_d;
  logic                restart_c;
  logic                timer_enable_c;
  logic                expired;

  assign wr_cnt_inc     = wr_cnt + WCNT_W'(1);
  assign timer_enable_c = is_phase(state);

  // Watchdog shared by all phases, restarted on every phase entry.
  histeq_phase_timer #(
    .TIMEOUT_W      (TIMEOUT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_phase_timer (
    .clock   (clock),
    .reset   (reset),
    .restart (restart_c),
    .enable  (timer_enable_c),
    .expired (expired)
  );

  // Next-state and flag logic; priority is clear, completion, protocol, watchdog.
  always_comb begin
    state_d    = state;
    read_fin_d = read_fin;
    wr_cnt_d   = wr_cnt;
    err_d      = err_code;
    restart_c  = 1'b0;
    if (clear) begin
      state_d    = IDLE;
      read_fin_d = 1'b0;
      wr_cnt_d   = '0;
      err_d      = ERR_NONE;
      restart_c  = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (go) begin
            state_d    = HIST;
            read_fin_d = 1'b0;
            wr_cnt_d   = '0;
            restart_c  = 1'b1;
          end
        end
        HIST: begin
          if (histogram_computation_done && read_fin) begin
            state_d    = CDF;
            read_fin_d = 1'b0;
            restart_c  = 1'b1;
          end else if (histogram_computation_done) begin
            state_d    = ERR;
            read_fin_d = 1'b0;
            err_d      = ERR_PROTOCOL;
          end else if (expired) begin
            state_d    = ERR;
            read_fin_d = 1'b0;
            err_d      = ERR_TIMEOUT;
          end else if (histogram_input_mem_raddr0 == LAST_RADDR) begin
            read_fin_d = 1'b1;
          end
        end
        CDF: begin
          if (cdf_done) begin
            state_d   = DIV;
            restart_c = 1'b1;
          end else if (expired) begin
            state_d = ERR;
            err_d   = ERR_TIMEOUT;
          end
        end
        DIV: begin
          if (divider_output_mem_WE) begin
            wr_cnt_d = wr_cnt_inc;
          end
          if (divider_output_mem_WE && (wr_cnt_inc == FINAL_WRITE)) begin
            state_d = FIN;
          end else if (expired) begin
            state_d = ERR;
            err_d   = ERR_TIMEOUT;
          end
        end
        FIN: begin
          state_d = IDLE;
        end
        ERR: begin
          state_d = ERR;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, flags and registered outputs decoded from the next state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                   <= IDLE;
      read_fin                <= 1'b0;
      wr_cnt                  <= '0;
      err_code                <= ERR_NONE;
      start_histogram         <= 1'b0;
      start_cdf               <= 1'b0;
      start_divider           <= 1'b0;
      input_mem_read_finished <= 1'b0;
      busy                    <= 1'b0;
      done                    <= 1'b0;
      error                   <= 1'b0;
    end else begin
      state                   <= state_d;
      read_fin                <= read_fin_d;
      wr_cnt                  <= wr_cnt_d;
      err_code                <= err_d;
      start_histogram         <= (state_d == HIST);
      start_cdf               <= (state_d == CDF);
      start_divider           <= (state_d == DIV);
      input_mem_read_finished <= read_fin_d;
      busy                    <= is_phase(state_d);
      done                    <= (state_d == FIN);
      error                   <= (state_d == ERR);
    end
  end

endmodule

// File: tb/tb_histeq_master_sequencer.sv
// Scoreboard bench for histeq_master_sequencer with small word counts and timeout.
module tb_histeq_master_sequencer;

  logic        clock;
  logic        reset;
  logic        go;
  logic        clear;
  logic        hcd;
  logic        cdf_done;
  logic [15:0] raddr;
  logic        we;
  logic        start_histogram;
  logic        start_cdf;
  logic        start_divider;
  logic        input_mem_read_finished;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  string      name_q[$];
  logic [8:0] obs;

  // Expected output vectors: {sh, sc, sd, rf, busy, done, error, err_code}
  localparam logic [8:0] E_IDLE  = 9'b0000_000_00;
  localparam logic [8:0] E_HIST  = 9'b1000_100_00;
  localparam logic [8:0] E_HISTF = 9'b1001_100_00;
  localparam logic [8:0] E_CDF   = 9'b0100_100_00;
  localparam logic [8:0] E_DIV   = 9'b0010_100_00;
  localparam logic [8:0] E_FIN   = 9'b0000_010_00;
  localparam logic [8:0] E_ERRP  = 9'b0000_001_10;
  localparam logic [8:0] E_ERRT  = 9'b0000_001_01;

  histeq_master_sequencer #(
    .INPUT_WORDS    (4),
    .OUTPUT_WORDS   (4),
    .TIMEOUT_W      (20),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clock                      (clock),
    .reset                      (reset),
    .go                         (go),
    .clear                      (clear),
    .histogram_computation_done (hcd),
    .cdf_done                   (cdf_done),
    .histogram_input_mem_raddr0 (raddr),
    .divider_output_mem_WE      (we),
    .start_histogram            (start_histogram),
    .start_cdf                  (start_cdf),
    .start_divider              (start_divider),
    .input_mem_read_finished    (input_mem_read_finished),
    .busy                       (busy),
    .done                       (done),
    .error                      (error),
    .err_code                   (err_code)
  );

  assign obs = {start_histogram, start_cdf, start_divider, input_mem_read_finished,
                busy, done, error, err_code};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Scoreboard: pop the expectation queued with each stimulus cycle and compare.
  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [8:0] want;
      string      nm;
      want = exp_q.pop_front();
      nm   = name_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL %s: got %b expected %b (sh sc sd rf busy done err code)", nm, obs, want);
      end
    end
  end

  // Drive one cycle of inputs and queue the output expected after the next edge.
  task automatic step(input logic g, input logic clr, input logic h, input logic c,
                      input logic w, input logic [15:0] ra, input logic [8:0] e,
                      input string nm);
    @(negedge clock);
    go = g; clear = clr; hcd = h; cdf_done = c; we = w; raddr = ra;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clock);
    #2;
  endtask

  task automatic idle_step(input logic [8:0] e, input string nm);
    step(0, 0, 0, 0, 0, 16'd0, e, nm);
  endtask

  // Walk HIST with a full address sweep and land in CDF.
  task automatic run_to_cdf(input string tag);
    step(1, 0, 0, 0, 0, 16'd0, E_HIST, {tag, "_go"});
    for (int a = 0; a < 3; a++) step(0, 0, 0, 0, 0, 16'(a), E_HIST, {tag, "_sweep"});
    step(0, 0, 0, 0, 0, 16'd3, E_HISTF, {tag, "_lastaddr"});
    step(0, 0, 1, 0, 0, 16'd0, E_CDF, {tag, "_hist_done"});
  endtask

  task automatic test_reset();
    reset = 1'b0; go = 0; clear = 0; hcd = 0; cdf_done = 0; we = 0; raddr = '0;
    #2;
    checks++;
    if (obs !== E_IDLE) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", obs, E_IDLE);
    end
    @(negedge clock);
    reset = 1'b1;
    idle_step(E_IDLE, "reset_idle");
  endtask

  task automatic test_nominal();
    run_to_cdf("nom");
    idle_step(E_CDF, "nom_cdf_hold");
    step(0, 0, 0, 1, 0, 16'd0, E_DIV, "nom_cdf_done");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 16'd0, E_DIV, "nom_we");
    idle_step(E_DIV, "nom_we_gap");
    step(0, 0, 0, 0, 1, 16'd0, E_FIN, "nom_final_we");
    idle_step(E_IDLE, "nom_done_drop");
  endtask

  task automatic test_protocol();
    step(1, 0, 0, 0, 0, 16'd0, E_HIST, "prot_go");
    step(0, 0, 0, 0, 0, 16'd1, E_HIST, "prot_addr1");
    step(0, 0, 1, 0, 0, 16'd2, E_ERRP, "prot_early_done");
    idle_step(E_ERRP, "prot_err_hold");
    step(1, 0, 0, 0, 0, 16'd0, E_ERRP, "prot_go_in_err");
    step(0, 1, 0, 0, 0, 16'd0, E_IDLE, "prot_clear");
    step(1, 1, 0, 0, 0, 16'd0, E_IDLE, "prot_clear_beats_go");
  endtask

  task automatic test_watchdog();
    step(1, 0, 0, 0, 0, 16'd0, E_HIST, "wd_hist_go");
    for (int i = 0; i < 7; i++) idle_step(E_HIST, "wd_hist_wait");
    idle_step(E_ERRT, "wd_hist_expire");
    step(0, 1, 0, 0, 0, 16'd0, E_IDLE, "wd_clear1");
    run_to_cdf("wdc");
    for (int i = 0; i < 7; i++) idle_step(E_CDF, "wd_cdf_wait");
    idle_step(E_ERRT, "wd_cdf_expire");
    idle_step(E_ERRT, "wd_err_hold");
    step(0, 1, 0, 0, 0, 16'd0, E_IDLE, "wd_clear2");
    run_to_cdf("wdw");
    for (int i = 0; i < 7; i++) idle_step(E_CDF, "wd_cdf_wait2");
    step(0, 0, 0, 1, 0, 16'd0, E_DIV, "wd_completion_wins");
    for (int i = 0; i < 7; i++) idle_step(E_DIV, "wd_div_wait");
    idle_step(E_ERRT, "wd_div_expire");
    step(0, 1, 0, 0, 0, 16'd0, E_IDLE, "wd_clear3");
  endtask

  task automatic test_spurious();
    step(1, 0, 0, 0, 0, 16'd0, E_HIST, "sp_go");
    step(1, 0, 0, 0, 1, 16'd1, E_HIST, "sp_we_hist");
    step(0, 0, 0, 0, 1, 16'd3, E_HISTF, "sp_we_lastaddr");
    step(1, 0, 0, 0, 1, 16'd0, E_HISTF, "sp_flag_sticky");
    step(0, 0, 1, 0, 1, 16'd0, E_CDF, "sp_hist_done");
    step(1, 0, 0, 0, 1, 16'd0, E_CDF, "sp_we_cdf");
    step(0, 0, 0, 1, 0, 16'd0, E_DIV, "sp_cdf_done");
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 16'd0, E_DIV, "sp_div_we");
    step(0, 0, 0, 0, 1, 16'd0, E_FIN, "sp_final_we");
    idle_step(E_IDLE, "sp_idle");
  endtask

  task automatic test_clear_mid_div();
    run_to_cdf("cl");
    step(0, 0, 0, 1, 0, 16'd0, E_DIV, "cl_div");
    step(0, 0, 0, 0, 1, 16'd0, E_DIV, "cl_we1");
    step(0, 0, 0, 0, 1, 16'd0, E_DIV, "cl_we2");
    step(0, 1, 0, 0, 0, 16'd0, E_IDLE, "cl_clear");
    run_to_cdf("cl2");
    step(0, 0, 0, 1, 0, 16'd0, E_DIV, "cl2_div");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 16'd0, E_DIV, "cl2_count_restarted");
    step(0, 0, 0, 0, 1, 16'd0, E_FIN, "cl2_final_we");
    idle_step(E_IDLE, "cl2_idle");
  endtask

  task automatic test_async_reset();
    step(1, 0, 0, 0, 0, 16'd0, E_HIST, "ar_go");
    step(0, 0, 0, 0, 0, 16'd3, E_HISTF, "ar_flag");
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== E_IDLE) begin
      errors++;
      $display("FAIL async_reset_immediate: got %b expected %b", obs, E_IDLE);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    idle_step(E_IDLE, "ar_idle_after");
    step(1, 0, 0, 0, 0, 16'd0, E_HIST, "ar_go_again");
    step(0, 1, 0, 0, 0, 16'd0, E_IDLE, "ar_clear");
  endtask

  task automatic test_drain();
    @(negedge clock);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_protocol();
    test_watchdog();
    test_spurious();
    test_clear_mid_div();
    test_async_reset();
    test_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
